// File: rtl/mem_ctrl_if.sv
// Client-side request/response signals and the 8-bit RAM/IO bus of mem_ctrl.
// The slave modport is the controller's view; master is the core plus RAM side.
interface mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_done;
    logic [31:0]           if_data;

    logic                  ls_req;
    logic                  ls_wr;
    logic [1:0]            ls_size;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [31:0]           ls_wdata;
    logic                  ls_done;
    logic [31:0]           ls_rdata;

    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;

    modport slave (
        input  if_req, if_addr,
        output if_done, if_data,
        input  ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
        output ls_done, ls_rdata,
        input  mem_din,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_req, if_addr,
        input  if_done, if_data,
        output ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
        input  ls_done, ls_rdata,
        output mem_din,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: round-robin between fetch and load/store clients,
// splitting 1/2/4-byte accesses into byte bus cycles and assembling reads little-endian.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    input  logic       clr_in,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                state_q;
    logic                  is_fetch_q;
    logic                  prefer_ls_q;
    logic [2:0]            nbytes_q;
    logic [2:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rbuf_q;

    logic                  if_done_q;
    logic [31:0]           if_data_q;
    logic                  ls_done_q;
    logic [31:0]           ls_rdata_q;
    logic [7:0]            mem_dout_q;
    logic [ADDR_WIDTH-1:0] mem_a_q;
    logic                  mem_wr_q;

    logic [2:0]            step_d;
    logic                  idle_free_d;
    logic                  if_ok_d;
    logic                  take_ls_d;
    logic                  take_if_d;
    logic [2:0]            ls_n_d;
    logic [31:0]           rbuf_d;
    logic [7:0]            wlane_d [4];
    logic [7:0]            wbyte_d;

    // step_d is the index of the edge about to happen, counted from acceptance (E0)
    assign step_d      = cnt_q + 3'd1;
    assign idle_free_d = (state_q == IDLE) && !if_done_q && !ls_done_q;
    assign if_ok_d     = bus.if_req && !clr_in;
    assign take_ls_d   = idle_free_d && bus.ls_req && (!if_ok_d || prefer_ls_q);
    assign take_if_d   = idle_free_d && if_ok_d && !take_ls_d;

    always_comb begin
        ls_n_d = 3'd4;
        case (bus.ls_size)
            2'b00:   ls_n_d = 3'd1;
            2'b01:   ls_n_d = 3'd2;
            default: ls_n_d = 3'd4;
        endcase
    end

    // Byte k arrives from the RAM one cycle after its address, i.e. at edge E(k+2)
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rbuf_d[8*gi +: 8] = (state_q == READ && step_d == 3'(gi + 2))
                                       ? bus.mem_din : rbuf_q[8*gi +: 8];
            assign wlane_d[gi] = wdata_q[8*gi +: 8];
        end
    endgenerate

    assign wbyte_d = wlane_d[step_d[1:0]];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            is_fetch_q  <= 1'b0;
            prefer_ls_q <= 1'b1;
            nbytes_q    <= '0;
            cnt_q       <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            if_done_q   <= 1'b0;
            if_data_q   <= '0;
            ls_done_q   <= 1'b0;
            ls_rdata_q  <= '0;
            mem_dout_q  <= '0;
            mem_a_q     <= '0;
            mem_wr_q    <= 1'b0;
        end else if (rdy_in) begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take_ls_d) begin
                        is_fetch_q  <= 1'b0;
                        prefer_ls_q <= 1'b0;
                        base_q      <= bus.ls_addr;
                        wdata_q     <= bus.ls_wdata;
                        nbytes_q    <= ls_n_d;
                        cnt_q       <= '0;
                        rbuf_q      <= '0;
                        mem_a_q     <= bus.ls_addr;
                        mem_dout_q  <= bus.ls_wdata[7:0];
                        mem_wr_q    <= bus.ls_wr;
                        state_q     <= bus.ls_wr ? WRITE : READ;
                    end else if (take_if_d) begin
                        is_fetch_q  <= 1'b1;
                        prefer_ls_q <= 1'b1;
                        base_q      <= bus.if_addr;
                        nbytes_q    <= 3'd4;
                        cnt_q       <= '0;
                        rbuf_q      <= '0;
                        mem_a_q     <= bus.if_addr;
                        mem_wr_q    <= 1'b0;
                        state_q     <= READ;
                    end
                end
                READ: begin
                    if (is_fetch_q && clr_in) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q  <= step_d;
                        rbuf_q <= rbuf_d;
                        if (step_d < nbytes_q) begin
                            mem_a_q <= base_q + ADDR_WIDTH'(step_d);
                        end
                        if (step_d == nbytes_q + 3'd1) begin
                            state_q <= IDLE;
                            if (is_fetch_q) begin
                                if_done_q <= 1'b1;
                                if_data_q <= rbuf_d;
                            end else begin
                                ls_done_q  <= 1'b1;
                                ls_rdata_q <= rbuf_d;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (step_d == nbytes_q) begin
                        mem_wr_q  <= 1'b0;
                        ls_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q      <= step_d;
                        mem_a_q    <= base_q + ADDR_WIDTH'(step_d);
                        mem_dout_q <= wbyte_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.if_done  = if_done_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_done  = ls_done_q;
    assign bus.ls_rdata = ls_rdata_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_wr   = mem_wr_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide synchronous RAM model on the bus.
module tb_mem_ctrl;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    logic clr_in = 1'b0;

    mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .clr_in (clr_in),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    // RAM shares the global freeze: it only advances while rdy_in is high
    logic [7:0] ram [0:65535];
    always @(posedge clk_in) begin
        if (rdy_in) begin
            bus.mem_din <= ram[bus.mem_a[15:0]];
            if (bus.mem_wr) ram[bus.mem_a[15:0]] = bus.mem_dout;
        end
    end

    int if_done_cnt = 0;
    int ls_done_cnt = 0;
    always @(posedge clk_in) begin
        if (bus.if_done) if_done_cnt++;
        if (bus.ls_done) ls_done_cnt++;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] a_log [8];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Runs one request to completion; cyc = posedges from request until done seen (0 = timeout)
    task automatic xfer(input bit fetch, input logic wr, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd, output int cyc);
        cyc = 0;
        if (fetch) begin
            bus.if_addr = addr; bus.if_req = 1'b1;
        end else begin
            bus.ls_addr = addr; bus.ls_wr = wr; bus.ls_size = sz;
            bus.ls_wdata = wd; bus.ls_req = 1'b1;
        end
        for (int i = 1; i <= 40 && cyc == 0; i++) begin
            @(posedge clk_in); @(negedge clk_in);
            if (i <= 8) a_log[i-1] = bus.mem_a;
            if (fetch ? bus.if_done : bus.ls_done) cyc = i;
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        if (cyc == 0) check_val("xfer_timeout", 32'd0, 32'd1);
        $display("xfer fetch=%0d wr=%0d size=%0d addr=%h wdata=%h -> cycles=%0d if_data=%h ls_rdata=%h",
                 fetch, wr, sz, addr, wd, cyc, bus.if_data, bus.ls_rdata);
    endtask

    // Raises both requests together; reports which done came first
    task automatic both_round(output bit ls_first);
        bit got_if, got_ls;
        got_if = 0; got_ls = 0; ls_first = 0;
        bus.if_addr = 32'h100; bus.if_req = 1'b1;
        bus.ls_addr = 32'h4000; bus.ls_wr = 1'b0; bus.ls_size = 2'b10; bus.ls_req = 1'b1;
        for (int i = 0; i < 60 && !(got_if && got_ls); i++) begin
            @(posedge clk_in); @(negedge clk_in);
            if (bus.ls_done && !got_ls) begin
                if (!got_if) ls_first = 1;
                got_ls = 1; bus.ls_req = 1'b0;
            end
            if (bus.if_done && !got_if) begin
                got_if = 1; bus.if_req = 1'b0;
            end
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        if (!(got_if && got_ls)) check_val("both_timeout", 32'd0, 32'd1);
        $display("both round: ls_first=%0d if_data=%h ls_rdata=%h", ls_first, bus.if_data, bus.ls_rdata);
    endtask

    initial begin
        int  cyc;
        int  base_cnt;
        bit  ls_first;

        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13;
        ram[16'h2003] = 8'h55;
        ram[16'h3000] = 8'h80;
        ram[16'h4000] = 8'h11; ram[16'h4001] = 8'h22;
        ram[16'h4002] = 8'h33; ram[16'h4003] = 8'h44;
        ram[16'hFFFF] = 8'hAB; ram[16'h0000] = 8'hCD;

        bus.if_req = 0; bus.if_addr = '0;
        bus.ls_req = 0; bus.ls_wr = 0; bus.ls_size = '0; bus.ls_addr = '0; bus.ls_wdata = '0;

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_val("rst_done", {30'd0, bus.if_done, bus.ls_done}, 32'd0);
        check_val("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        check_val("rst_mem_a", bus.mem_a, 32'd0);
        check_val("rst_if_data", bus.if_data, 32'd0);
        check_val("rst_ls_rdata", bus.ls_rdata, 32'd0);
        rst_in = 1'b0;

        // Word fetch
        xfer(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, cyc);
        check_val("fetch_lat", cyc, 32'd6);
        check_val("fetch_data", bus.if_data, 32'h00000013);
        for (int k = 0; k < 4; k++) check_val("fetch_mem_a", a_log[k], 32'h100 + k);
        @(negedge clk_in);
        check_val("fetch_done_1cyc", {31'd0, bus.if_done}, 32'd0);

        // Half store, unaligned
        xfer(1'b0, 1'b1, 2'b01, 32'h2001, 32'hDEADBEEF, cyc);
        check_val("st_lat", cyc, 32'd3);
        check_val("st_b0", {24'd0, ram[16'h2001]}, 32'hEF);
        check_val("st_b1", {24'd0, ram[16'h2002]}, 32'hBE);
        check_val("st_b2_untouched", {24'd0, ram[16'h2003]}, 32'h55);
        check_val("st_mem_wr_off", {31'd0, bus.mem_wr}, 32'd0);
        @(negedge clk_in);

        // Byte load, zero-extended
        xfer(1'b0, 1'b0, 2'b00, 32'h3000, 32'h0, cyc);
        check_val("ldb_lat", cyc, 32'd3);
        check_val("ldb_data", bus.ls_rdata, 32'h00000080);
        @(negedge clk_in);

        // Half load crossing the top of the address space
        xfer(1'b0, 1'b0, 2'b01, 32'hFFFFFFFF, 32'h0, cyc);
        check_val("wrap_a0", a_log[0], 32'hFFFFFFFF);
        check_val("wrap_a1", a_log[1], 32'h00000000);
        check_val("wrap_data", bus.ls_rdata, 32'h0000CDAB);
        @(negedge clk_in);

        // Arbitration from reset
        rst_in = 1'b1;
        @(posedge clk_in); @(negedge clk_in);
        rst_in = 1'b0;
        both_round(ls_first);
        check_val("rr1_ls_first", {31'd0, ls_first}, 32'd1);
        check_val("rr1_ls_data", bus.ls_rdata, 32'h44332211);
        check_val("rr1_if_data", bus.if_data, 32'h00000013);
        @(negedge clk_in);
        both_round(ls_first);
        check_val("rr2_ls_first", {31'd0, ls_first}, 32'd1);
        @(negedge clk_in);
        xfer(1'b0, 1'b0, 2'b00, 32'h3000, 32'h0, cyc);
        @(negedge clk_in);
        both_round(ls_first);
        check_val("rr3_if_first", {31'd0, ls_first}, 32'd0);
        @(negedge clk_in);

        // Flush during cycle 2 of a fetch
        base_cnt = if_done_cnt;
        bus.if_addr = 32'h4000; bus.if_req = 1'b1;
        @(posedge clk_in); @(negedge clk_in);
        @(posedge clk_in); @(negedge clk_in);
        clr_in = 1'b1; bus.if_req = 1'b0;
        @(posedge clk_in); @(negedge clk_in);
        clr_in = 1'b0;
        check_val("clr_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        xfer(1'b0, 1'b0, 2'b00, 32'h3000, 32'h0, cyc);
        check_val("clr_ls_lat", cyc, 32'd3);
        check_val("clr_ls_data", bus.ls_rdata, 32'h00000080);
        repeat (4) @(negedge clk_in);
        check_val("clr_no_if_done", if_done_cnt - base_cnt, 32'd0);
        check_val("clr_if_data_held", bus.if_data, 32'h00000013);

        // Freeze for 3 cycles in the middle of a word load
        cyc = 0;
        bus.ls_addr = 32'h4000; bus.ls_wr = 1'b0; bus.ls_size = 2'b11; bus.ls_req = 1'b1;
        for (int i = 1; i <= 40 && cyc == 0; i++) begin
            @(posedge clk_in); @(negedge clk_in);
            if (bus.ls_done) cyc = i;
            if (i == 2) rdy_in = 1'b0;
            if (i == 5) begin
                check_val("stall_mem_a", bus.mem_a, 32'h4001);
                rdy_in = 1'b1;
            end
        end
        bus.ls_req = 1'b0;
        $display("stalled load addr=00004000 -> cycles=%0d ls_rdata=%h", cyc, bus.ls_rdata);
        check_val("stall_lat", cyc, 32'd9);
        check_val("stall_data", bus.ls_rdata, 32'h44332211);
        @(negedge clk_in);

        // Reset in the middle of a word store
        base_cnt = ls_done_cnt;
        bus.ls_addr = 32'h5000; bus.ls_wr = 1'b1; bus.ls_size = 2'b10;
        bus.ls_wdata = 32'h01020304; bus.ls_req = 1'b1;
        @(posedge clk_in); @(negedge clk_in);
        @(posedge clk_in); @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in); @(negedge clk_in);
        check_val("rst_mid_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        rst_in = 1'b0; bus.ls_req = 1'b0;
        repeat (6) @(negedge clk_in);
        check_val("rst_mid_no_done", ls_done_cnt - base_cnt, 32'd0);
        check_val("rst_mid_b0", {24'd0, ram[16'h5000]}, 32'h04);
        check_val("rst_mid_b2", {24'd0, ram[16'h5002]}, 32'h00);
        $display("reset mid-store addr=00005000: ram[5000..5003]=%h %h %h %h",
                 ram[16'h5000], ram[16'h5001], ram[16'h5002], ram[16'h5003]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller between the core's two memory clients (instruction fetch, load/store unit) and the 8-bit synchronous single-port RAM/IO bus.
- Arbitrates the clients, splits each 1/2/4-byte access into per-byte bus cycles with incrementing addresses, and assembles read bytes little-endian into 32-bit results.
- Provides a flush that abandons an in-flight instruction fetch.

Parameters:
- ADDR_WIDTH, 32: width of client and bus addresses.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global ready; low = freeze
- clr_in  in  1  flush; abandons instruction fetch
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_WIDTH  fetch address, 4 bytes
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched word
- ls_req  in  1  data request, held until ls_done
- ls_wr  in  1  1 = store, 0 = load
- ls_size  in  2  00 byte, 01 half, 10/11 word
- ls_addr  in  ADDR_WIDTH  data address
- ls_wdata  in  32  store data, low bytes used
- ls_done  out  1  one-cycle pulse
- ls_rdata  out  32  load data, zero-extended
- mem_din  in  8  RAM read data; valid the cycle after an address is presented
- mem_dout  out  8  RAM write data
- mem_a  out  ADDR_WIDTH  RAM byte address
- mem_wr  out  1  1 = write (inverted externally to the RAM read/not-write input)

Behaviour:
- Clock and reset: single clock clk_in. Reset rst_in is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; round-robin pointer favours ls.
- rdy_in low: every register holds, including state, counters, mem_* and done. Resumes exactly where it stopped.
- States:
  - IDLE: no access in progress.
  - READ: bytes issued/captured via counters, N = byte count.
  - WRITE: bytes issued via counter.
- Acceptance (IDLE only; not in a cycle where if_done or ls_done is high):
  - Both requests pending: serve the client not served last.
  - If only one is pending, serve it.
  - if_req is not accepted in a cycle with clr_in high.
  - Address, size and wdata are latched at the acceptance edge E0.
- Read, N bytes:
  - From E0 through E(N-1), register mem_a = base+k and mem_wr = 0.
  - Byte k is sampled from mem_din at edge E(k+2) into bits [8k+7:8k].
  - At E(N+1): done = 1, data is registered, state = IDLE.
  - 4-byte fetch: done high in the 6th cycle after E0.
- Write, N bytes:
  - From E0 through E(N-1), register mem_a = base+k, mem_dout = wdata[8k+7:8k], mem_wr = 1.
  - At E(N): mem_wr = 0, ls_done = 1, state = IDLE.
- Address arithmetic: 32-bit wrap-around (0xFFFFFFFF+1 = 0). No alignment requirement.
- Done outputs: exactly one cycle per accepted request; rdata/if_data hold until the next completion.
- mem_wr is 0 whenever not in WRITE.
- clr_in:
  - While serving a fetch: next edge → IDLE, no if_done, mem_wr stays 0.
  - Pending if_req is dropped for that cycle.
  - During a data access: ignored; loads and stores always complete.
- Reset mid-access: access dropped, no done pulse. A partially written store is left as written.

Test Plan:
- Fetch if_addr=0x100, RAM[0x100..0x103]=13,00,00,00:
  - mem_a 0x100..0x103 in consecutive cycles.
  - if_done one cycle, 6 cycles after acceptance.
  - if_data=0x00000013.
- Store ls_size=01, ls_addr=0x2001, ls_wdata=0xDEADBEEF:
  - Writes EF@0x2001, BE@0x2002.
  - ls_done at E2; RAM[0x2003] unchanged.
- Byte load of 0x80: ls_rdata=0x00000080, zero-extended.
- if_req and ls_req together from reset:
  - ls served first, then fetch.
  - Repeat both: fetch-first ordering alternates.
- clr_in during cycle 2 of a fetch:
  - IDLE next cycle, no if_done.
  - Following ls_req is accepted immediately.
- rdy_in low for 3 cycles mid-load:
  - mem_a frozen; result identical, done delayed by exactly 3 cycles.
- rst_in mid-store: mem_wr=0 next cycle; no ls_done.
